alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Shares one 16-bit four-function ALU instance (add/sub/and/or, op[1:0]) between
//  NUM_REQ requesters. Each requester issues a valid/ready operation. Grants are
//  round-robin. The block drives registered operands into the external ALU and
//  captures its result. It returns the result tagged with the requester ID.
//  It sits between the requester ports and the ALU instance.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  WIDTH    16  operand/result width; must match the ALU instance
//  IDW      2   requester ID width = clog2(NUM_REQ)
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  req_valid  in   NUM_REQ        per-requester operation valid
//  req_ready  out  NUM_REQ        per-requester accept (at most one bit high)
//  req_a      in   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NUM_REQ*WIDTH  operand B, same packing
//  req_op     in   NUM_REQ*2      op, 00 add / 01 sub / 10 and / 11 or
//  alu_a      out  WIDTH          registered operand A to ALU
//  alu_b      out  WIDTH          registered operand B to ALU
//  alu_op     out  2              registered op to ALU (op1=bit1, op0=bit0)
//  alu_y      in   WIDTH          combinational ALU result
//  rsp_valid  out  1              result valid
//  rsp_ready  in   1              result consumer ready
//  rsp_data   out  WIDTH          captured result
//  rsp_id     out  IDW            ID of the requester that owns rsp_data
//  busy       out  1              high whenever state != IDLE
// BEHAVIOUR
//  - Reset values (async, rst_n=0): state=IDLE, alu_a/alu_b=0, alu_op=00,
//    rsp_valid=0, rsp_data=0, rsp_id=0, RR pointer=0. req_ready=0 while rst_n=0.
//  - FSM states:
//    - IDLE: req_ready = onehot round-robin grant over req_valid, starting at the
//      pointer. The grant is combinational from req_valid and the pointer, and is
//      0 in other states. On handshake to requester g: latch its a/b/op into
//      alu_a/alu_b/alu_op, latch g as rsp_id, set pointer=(g+1)%NUM_REQ, go to EXEC.
//      With no req_valid, stay in IDLE.
//    - EXEC: exactly one cycle. Operands are stable. On the clock edge,
//      rsp_data<=alu_y, rsp_valid<=1, go to RESP.
//    - RESP: rsp_valid=1. rsp_data and rsp_id hold stable until rsp_ready=1.
//      On handshake: rsp_valid<=0, go to IDLE.
//  - Latency: handshake on cycle N, rsp_valid high on cycle N+2. Minimum issue
//    interval is 3 cycles; no overlap or pipelining.
//  - alu_a/alu_b/alu_op hold their last values outside EXEC (no toggling).
//  - Pointer wraps from NUM_REQ-1 to 0. An all-zero req_valid leaves the pointer
//    unchanged.
//  - Requester rules: a requester must hold req_valid and its fields stable until
//    req_ready. Dropping req_valid before grant is legal; the request is then
//    simply not served.
//  - A requester whose req_valid is still high after its own grant competes
//    normally next IDLE, at lowest priority.
//  - Reset mid-operation (EXEC or RESP): the pending result is discarded and
//    rsp_valid drops asynchronously. No response is ever issued for it.
//  - The controller does not interpret arithmetic; the result is whatever alu_y
//    gives for the latched op. Carry-out is not exported.
// STRUCTURE
//  - Package alu_ctrl_pkg: alu_op_e {OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10,
//    OP_OR=2'b11}, ctrl_state_e {IDLE, EXEC, RESP}, localparam ALU_W=16.
//  - Sub-module rr_arbiter #(N): inputs req, ptr, en; outputs onehot gnt and
//    binary gnt_id.
//  - Top level: FSM, operand/result registers and pointer register.
//  - The ALU is instantiated outside this block (bench or parent).
// TESTING (bench instantiates the team 16-bit ALU on alu_*)
//  1. Single add: req0 a=0x0005 b=0x0003 op=00 -> req_ready[0] same cycle;
//     rsp_valid at N+2, rsp_data=0x0008, rsp_id=0.
//  2. All four requesters valid from IDLE, pointer=0, rsp_ready=1 -> grants 0,1,2,3,
//     one per 3 cycles, rsp_id sequence 0,1,2,3. Next round restarts at 0.
//  3. Backpressure: and op a=0xF0F0 b=0xFF00, rsp_ready=0 for 5 cycles ->
//     rsp_valid stays 1, rsp_data=0xF000 stable, all req_ready=0, busy=1.
//  4. Pointer wrap: pointer=3, req_valid=4'b1001 -> req 3 granted first, then req 0.
//     Or op a=0x00FF b=0x0F00 -> 0x0FFF.
//  5. Reset in RESP: assert rst_n=0 -> rsp_valid=0 immediately. After release:
//     state IDLE, pointer=0, no stale response.
//  6. Sub op via any requester: rsp_data equals the ALU model output for the
//     latched a/b, and alu_op=01 is held for the whole EXEC cycle.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU-sharing controller.
//   alu_op_e     : op encoding driven to the external 4-function ALU
//   ctrl_state_e : controller FSM states
//   ALU_W        : operand/result width of the team ALU
package alu_ctrl_pkg;
  localparam int ALU_W = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i    : request vector
//   ptr_i    : highest-priority index this cycle
//   en_i     : grant enable; gnt_o is all-zero when low
//   gnt_o    : onehot grant
//   gnt_id_o : binary index of the granted request (0 when no grant)
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  input  logic           en_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o
);
  int   idx;
  logic found;

  // Walk the requests starting at ptr_i; first hit wins.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between NUM_REQ requesters.
// A request is granted round-robin in IDLE, its operands are registered onto
// alu_*_o for one EXEC cycle, the ALU result is captured and then held on
// rsp_*_o (tagged with the requester ID) until the consumer takes it.
//   clk, rst_n          : clock, async active-low reset
//   req_valid_i/ready_o : per-requester handshake (ready is onehot or zero)
//   req_a_i/b_i/op_i    : packed per-requester operands, requester i at [i*W +: W]
//   alu_a_o/b_o/op_o    : registered operands to the ALU
//   alu_y_i             : ALU result
//   rsp_valid_o/ready_i : result handshake
//   rsp_data_o/id_o     : captured result and owning requester
//   busy_o              : high whenever the controller is not IDLE
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = ALU_W,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*2-1:0]     req_op_i,
  output logic [WIDTH-1:0]         alu_a_o,
  output logic [WIDTH-1:0]         alu_b_o,
  output logic [1:0]               alu_op_o,
  input  logic [WIDTH-1:0]         alu_y_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic [IDW-1:0]           rsp_id_o,
  output logic                     busy_o
);
  ctrl_state_e      state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_data_q;
  alu_op_e          alu_op_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_valid_q;

  logic             arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic             req_hs;

  // Grant only in IDLE and never while reset is held, even though the
  // state register already reads IDLE during reset.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .gnt_o   (gnt),
    .gnt_id_o(gnt_id)
  );

  // The grant is a subset of req_valid, so any grant is a handshake.
  assign req_hs = |gnt;
  assign ptr_d  = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o = gnt;
    busy_o      = (state_q != IDLE);
  end

  // Operand, result and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_ADD;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      if (state_q == IDLE && req_hs) begin
        alu_a_q  <= req_a_i[gnt_id*WIDTH +: WIDTH];
        alu_b_q  <= req_b_i[gnt_id*WIDTH +: WIDTH];
        alu_op_q <= alu_op_e'(req_op_i[gnt_id*2 +: 2]);
        rsp_id_q <= gnt_id;
        ptr_q    <= ptr_d;
      end
      if (state_q == EXEC) begin
        rsp_data_q  <= alu_y_i;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == RESP && rsp_ready_i) rsp_valid_q <= 1'b0;
    end
  end

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_op_o    = alu_op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed + randomized bench for alu_share_ctrl with a behavioural ALU on
// the alu_* side and a transaction-level reference model (RR pointer kept as
// an integer, results computed arithmetically).
module tb_alu_share_ctrl;
  localparam int N = 4;
  localparam int W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0][W-1:0] ma, mb;
  logic [N-1:0][1:0] mop;
  logic [W-1:0]      alu_a, alu_b, alu_y, rsp_data;
  logic [1:0]        alu_op, rsp_id;
  logic              rsp_valid, rsp_ready, busy;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(ma), .req_b_i(mb), .req_op_i(mop),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_y_i(alu_y),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_id_o(rsp_id), .busy_o(busy)
  );

  // Stand-in for the team 16-bit ALU
  always_comb begin
    case (alu_op)
      2'b00:   alu_y = alu_a + alu_b;
      2'b01:   alu_y = alu_a + ~alu_b + 16'd1;
      2'b10:   alu_y = alu_a & alu_b;
      default: alu_y = alu_a | alu_b;
    endcase
  end

  function automatic logic [W-1:0] ref_res(int a, int b, int op);
    int r;
    case (op)
      0:       r = (a + b) % 65536;
      1:       r = (a - b + 65536) % 65536;
      2:       r = a & b;
      default: r = a | b;
    endcase
    return W'(r);
  endfunction

  function automatic int exp_grant(logic [N-1:0] mask, int p);
    for (int k = 0; k < N; k++)
      if (mask[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      ma[i]  = W'($urandom);
      mb[i]  = W'($urandom);
      mop[i] = 2'($urandom_range(0, 3));
    end
  endtask

  // Called #1 after a clock edge with the DUT in IDLE. Runs one full
  // transaction with bp cycles of response backpressure; leaves DUT in IDLE.
  task automatic issue(input logic [N-1:0] mask, input int bp, input bit keep);
    int g;
    logic [W-1:0] ey;
    req_valid = mask;
    #1;
    g = exp_grant(mask, ptr_m);
    chk("grant", 32'(req_ready), 32'(1 << g));
    chk("idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
    ptr_m = (g + 1) % N;
    ey = ref_res(int'(ma[g]), int'(mb[g]), int'(mop[g]));
    if (!keep) req_valid[g] = 1'b0;
    chk("exec_ready", 32'(req_ready), 0);
    chk("exec_busy", 32'(busy), 1);
    chk("exec_valid", 32'(rsp_valid), 0);
    chk("exec_a", 32'(alu_a), 32'(ma[g]));
    chk("exec_b", 32'(alu_b), 32'(mb[g]));
    chk("exec_op", 32'(alu_op), 32'(mop[g]));
    #3;
    chk("exec_op_late", 32'(alu_op), 32'(mop[g]));
    @(posedge clk); #1;
    chk("resp_valid", 32'(rsp_valid), 1);
    chk("resp_data", 32'(rsp_data), 32'(ey));
    chk("resp_id", 32'(rsp_id), 32'(g));
    chk("resp_op_hold", 32'(alu_op), 32'(mop[g]));
    for (int c = 0; c < bp; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 32'(ey));
      chk("bp_id", 32'(rsp_id), 32'(g));
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("done_valid", 32'(rsp_valid), 0);
    chk("done_busy", 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = 4'hF;
    rand_ops();
    #2;
    // Reset values and ready suppression while reset is held
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_id", 32'(rsp_id), 0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. single add on requester 0
    ma[0] = 16'h0005; mb[0] = 16'h0003; mop[0] = 2'b00;
    issue(4'b0001, 0, 0);

    // 2. all four valid: 0,1,2,3 then wrap to 0
    rand_ops();
    for (int i = 0; i < 5; i++) issue(4'b1111, 0, 1);
    req_valid = '0;

    // idle with no requests: pointer must not move
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("noreq_busy", 32'(busy), 0);
      chk("noreq_ready", 32'(req_ready), 0);
    end

    // 3. backpressure on an AND
    rand_ops();
    ma[ptr_m] = 16'hF0F0; mb[ptr_m] = 16'hFF00; mop[ptr_m] = 2'b10;
    issue(4'b1111, 5, 0);
    req_valid = '0;

    // 4. pointer wrap: force pointer to 3, then 3 before 0
    rand_ops();
    issue(4'b0100, 0, 0);
    ma[3] = 16'h00FF; mb[3] = 16'h0F00; mop[3] = 2'b11;
    issue(4'b1001, 0, 0);
    issue(4'b0001, 0, 0);

    // 5. reset while in RESP
    rand_ops();
    req_valid = 4'b0010;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_data", 32'(rsp_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ptr_m = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("postrst_valid", 32'(rsp_valid), 0);
      chk("postrst_busy", 32'(busy), 0);
    end
    rsp_ready = 1'b0;
    rand_ops();
    issue(4'b1111, 0, 0);

    // 6. directed sub, then randomized traffic
    rand_ops();
    mop[2] = 2'b01;
    issue(4'b0100, 0, 0);
    for (int i = 0; i < 20; i++) begin
      rand_ops();
      issue(4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, 1));
    end
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
